frame_tx_arbiter: RTL
=====================

Name: frame_tx_arbiter

Overview:
- Shares one serial output line between N requesters, each presenting a 40-bit frame.
- Round-robin arbitration picks one requester. Its frame is serialized as: one start bit (1), then 40 data bits LSB first, then a low guard gap.
- The wire format matches the 40-bit serial frame receiver, so the two blocks can be looped back directly.
- Sits on the transmit side of the serial link, between the frame producers (audio, keyboard/mouse, status) and the pad.

Parameters:
- N, 3, number of requesters; legal range 2..8.
- FRAME_BITS, 40, data bits per frame.
- GAP, 4, cycles so is held low after the last data bit; must be >= 2 (the receiver needs 2 post-frame cycles).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset.
- req  in  N  request, one bit per requester. Level-held until granted; may be withdrawn before grant.
- data_in  in  N*FRAME_BITS  frames. Requester i occupies bits [i*FRAME_BITS +: FRAME_BITS]. Must be stable while req[i] is high.
- grant  out  N  one-hot, one-cycle pulse: the frame of that requester was latched.
- so  out  1  serial out; idle low.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse in the first GAP cycle.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: grant=0, so=0, busy=0, frame_done=0, state=IDLE, shift register=0, bit counter=0, RR pointer set so requester 0 has top priority.
- FSM states: IDLE, START, SHIFT, GAP.
- IDLE, req==0: remain in IDLE, so=0.
- IDLE, req!=0 at edge E0:
  - Select winner w = first requester with req set, searching from last_grant+1 upward modulo N.
  - Latch data_in slice w into the shift register; set last_grant=w.
  - Go to START. After E0: grant[w]=1 for exactly one cycle, so=1, busy=1.
- START to SHIFT at E1. After edge E1+k (k=0..39), so = frame bit k (LSB first; shift right each cycle). Bit counter runs 0..FRAME_BITS-1.
- SHIFT to GAP after the last bit. After E41: so=0, frame_done=1 for one cycle. GAP lasts GAP cycles, then IDLE.
- IDLE can accept at its first edge. Minimum low time between frames = GAP+1 cycles. Back-to-back period = FRAME_BITS+GAP+2 cycles (46 at defaults).
- Requests arriving in START/SHIFT/GAP are ignored until IDLE. No queueing: the requester keeps req high.
- req[i] dropped before grant: the frame is not sent and there is no side effect. A drop and an acceptance in the same cycle means the registered req value at the edge decides.
- data_in is sampled only at the accept edge. Changes afterwards do not affect the frame in flight.
- The RR pointer advances only on a grant. A single active requester is served every frame.
- rst asserted mid-frame: at that edge everything returns to the reset values and so drops to 0 immediately. The truncated frame is lost and no grant is reissued. System reset must also reset the downstream receiver.
- rst and req high at the same edge: reset wins; no grant.

Test Plan:
- Single frame: req[0]=1 with data 40'hA5_5A_0F_F0_3C, others idle.
  - grant=3'b001 for one cycle after the accept edge.
  - so = 1, then bits 0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1,... (LSB first) for 40 cycles, then low for 4 cycles.
  - frame_done pulses on the cycle after the last bit; busy is high for 45 cycles.
- Round robin: req=3'b111 held constantly with distinct frames. Grants go 0,1,2,0,1,2 at exactly 46-cycle spacing, and each so frame matches its requester's data.
- Loopback into the 40-bit serial receiver:
  - The receiver's data equals the sent frame for 40'h12_34_56_78_9A and 40'hFF_FF_FF_FF_FF, sent back-to-back.
  - data_recv_flag pulses once per frame, and the receiver never misses the second start bit.
- Reset at bit 20: rst for one cycle mid-SHIFT gives so=0, busy=0, grant=0 next cycle. The next grant goes to requester 0 even though 0 was last served.
- Withdraw and busy-ignore:
  - req[1] raised then dropped while busy gives no grant[1].
  - req[2] raised during SHIFT is granted only at the first IDLE edge, with no earlier so activity.
- GAP=2 variant: back-to-back period is 44 cycles, and loopback with the receiver still captures every frame.

Source files
------------

// File: rtl/frame_tx_arbiter.sv
// Round-robin arbiter that serializes one requester's 40-bit frame onto a shared line:
// start bit, data LSB first, then a low guard gap.
module frame_tx_arbiter #(
  parameter int unsigned N          = 3,
  parameter int unsigned FRAME_BITS = 40,
  parameter int unsigned GAP        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N*FRAME_BITS-1:0] data_in,
  output logic [N-1:0]            grant,
  output logic                    so,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned PW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_MAX = (FRAME_BITS > GAP) ? FRAME_BITS : GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         last_q, last_d;
  logic [N-1:0]          grant_q, grant_d;
  logic                  so_q, so_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  win_valid;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand;
  logic [FRAME_BITS-1:0] win_frame;

  // Search starts one past the last winner, so the most recently served requester is last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int o = 1; o <= int'(N); o++) begin
      cand = PW'((int'(last_q) + o) % int'(N));
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_frame = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (win_idx == PW'(i)) win_frame = data_in[i*FRAME_BITS +: FRAME_BITS];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = '0;
    so_d    = so_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        so_d = 1'b0;
        if (win_valid) begin
          shreg_d          = win_frame;
          last_d           = win_idx;
          grant_d[win_idx] = 1'b1;
          so_d             = 1'b1;
          state_d          = StStart;
        end
      end
      StStart: begin
        so_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q == CW'(FRAME_BITS - 1)) begin
          so_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          so_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      StGap: begin
        so_d = 1'b0;
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= PW'(N - 1);
      grant_q <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign grant      = grant_q;
  assign so         = so_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
